// File: rtl/dmem_pkg.sv
// Shared constants for the data-side responder: mailbox register offsets,
// STATUS bit positions and the mailbox register selector.
package dmem_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_RXDATA = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_COUNT  = 4'hC;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_TX_OVF   = 4;

    typedef enum logic [1:0] {
        REG_TXDATA = OFF_TXDATA[3:2],
        REG_RXDATA = OFF_RXDATA[3:2],
        REG_STATUS = OFF_STATUS[3:2],
        REG_COUNT  = OFF_COUNT[3:2]
    } mbox_reg_e;

    // Registers are word-sized, so the byte lane bits never affect selection.
    function automatic mbox_reg_e decode_reg(input logic [1:0] word_off);
        return mbox_reg_e'(word_off);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count; a push into a full FIFO is accepted only when
// a pop happens on the same edge. The head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side responder for the single-cycle core: decodes the load/store port
// into a word RAM and a byte mailbox built from a TX FIFO and an RX FIFO.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS   = 64,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] PERIPH_BASE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memwrite,
    input  logic        memread,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_q [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_hit, mbox_hit;
    mbox_reg_e         reg_sel;

    logic              tx_push, tx_full, tx_empty;
    logic [7:0]        tx_head;
    logic [CW-1:0]     tx_count;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]        rx_head;
    logic [CW-1:0]     rx_count;
    logic              tx_ovf_q, tx_ovf_d;
    logic [31:0]       status;

    assign ram_hit  = (addr < 32'(RAM_WORDS * 4));
    assign ram_idx  = addr[RAM_AW+1:2];
    assign mbox_hit = (addr[31:4] == PERIPH_BASE[31:4]);
    assign reg_sel  = decode_reg(addr[3:2]);

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_head;
    assign rx_ready = !rx_full;

    always_comb begin
        tx_push  = memwrite && mbox_hit && (reg_sel == REG_TXDATA);
        rx_push  = rx_valid && !rx_full;
        // A store on the same cycle owns the address, so it suppresses the pop.
        rx_pop   = memread && !memwrite && mbox_hit && (reg_sel == REG_RXDATA) && !rx_empty;
        tx_ovf_d = tx_ovf_q;
        if (tx_push && tx_full && !(tx_ready && !tx_empty)) begin
            tx_ovf_d = 1'b1;
        end
        if (memwrite && mbox_hit && (reg_sel == REG_STATUS) && wdata[ST_TX_OVF]) begin
            tx_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (wdata[7:0]),
        .pop       (tx_ready),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (memwrite && ram_hit) begin
            ram_q[ram_idx] <= wdata;
        end
    end

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_TX_OVF]   = tx_ovf_q;
        rdata               = '0;
        if (ram_hit) begin
            rdata = ram_q[ram_idx];
        end else if (mbox_hit) begin
            case (reg_sel)
                REG_RXDATA: rdata = {24'b0, rx_head};
                REG_STATUS: rdata = status;
                REG_COUNT:  rdata = {16'b0, 8'(rx_count), 8'(tx_count)};
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with TX/RX byte scoreboards and a small
// occupancy model for STATUS and COUNT.
module tb_dmem_responder;

    localparam logic [31:0] TXD = 32'h0000_1000;
    localparam logic [31:0] RXD = 32'h0000_1004;
    localparam logic [31:0] STS = 32'h0000_1008;
    localparam logic [31:0] CNT = 32'h0000_100C;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic        ovf_m = 1'b0;
    logic [31:0] got;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .memwrite (memwrite),
        .memread  (memread),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic we, input logic re);
        addr     = a;
        wdata    = d;
        memwrite = we;
        memread  = re;
        tick();
        memwrite = 1'b0;
        memread  = 1'b0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    // Accepted when there is room, or when the consumer frees a slot this edge.
    task automatic tx_store(input logic [7:0] d);
        if (tx_q.size() < DEPTH || (tx_ready && tx_q.size() > 0)) begin
            tx_q.push_back(d);
        end else begin
            ovf_m = 1'b1;
        end
        applyStimulus(TXD, {24'h0, d}, 1'b1, 1'b0);
    endtask

    task automatic rx_offer(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        if (rx_q.size() < DEPTH) begin
            rx_q.push_back(d);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic rx_load(input string tag);
        logic [31:0] exp;
        exp = (rx_q.size() > 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
        addr    = RXD;
        memread = 1'b1;
        #1;
        checkOutput(tag, rdata, exp);
        tick();
        memread = 1'b0;
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] r;
        r    = '0;
        r[0] = (tx_q.size() == DEPTH);
        r[1] = (tx_q.size() == 0);
        r[2] = (rx_q.size() == DEPTH);
        r[3] = (rx_q.size() == 0);
        r[4] = ovf_m;
        return r;
    endfunction

    function automatic logic [31:0] model_count();
        return {16'h0, 8'(rx_q.size()), 8'(tx_q.size())};
    endfunction

    task automatic check_state(input string tag);
        logic [31:0] v;
        read_reg(STS, v);
        checkOutput({tag, "_status"}, v, model_status());
        read_reg(CNT, v);
        checkOutput({tag, "_count"}, v, model_count());
        checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 32'(tx_q.size() > 0));
        checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'(rx_q.size() < DEPTH));
    endtask

    // Transfers are judged just before the edge that consumes them.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            checkOutput("tx_pending", 32'(tx_q.size() > 0), 32'h1);
            if (tx_q.size() > 0) begin
                checkOutput("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_tx_data", {24'h0, tx_data}, 32'h0);
        read_reg(STS, got);
        checkOutput("reset_status", got, 32'h0000_000A);
        check_state("reset");

        applyStimulus(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
        read_reg(32'h10, got);
        checkOutput("ram_0x10", got, 32'hDEAD_BEEF);
        read_reg(32'h13, got);
        checkOutput("ram_0x13", got, 32'hDEAD_BEEF);
        applyStimulus(32'h14, 32'h1234_5678, 1'b1, 1'b0);
        read_reg(32'h14, got);
        checkOutput("ram_0x14", got, 32'h1234_5678);
        read_reg(32'h10, got);
        checkOutput("ram_0x10_kept", got, 32'hDEAD_BEEF);
        applyStimulus(32'h800, 32'hFFFF_FFFF, 1'b1, 1'b0);
        read_reg(32'h800, got);
        checkOutput("unmapped_read", got, 32'h0);
        read_reg(TXD, got);
        checkOutput("txdata_read", got, 32'h0);

        tx_ready = 1'b0;
        tx_store(8'hA5);
        tx_store(8'h3C);
        checkOutput("tx_valid_up", 32'(tx_valid), 32'h1);
        checkOutput("tx_head", {24'h0, tx_data}, 32'hA5);
        read_reg(CNT, got);
        checkOutput("tx_count2", got, 32'h0000_0002);
        tx_ready = 1'b1;
        tick();
        tick();
        tx_ready = 1'b0;
        read_reg(STS, got);
        checkOutput("tx_empty_bit", {31'h0, got[1]}, 32'h1);
        check_state("tx_path");

        for (int i = 0; i < 9; i++) begin
            tx_store(8'(i));
        end
        read_reg(STS, got);
        checkOutput("ovf_status", got, 32'h0000_0019);
        check_state("ovf");
        applyStimulus(STS, 32'h10, 1'b1, 1'b0);
        ovf_m = 1'b0;
        read_reg(STS, got);
        checkOutput("ovf_cleared", {31'h0, got[4]}, 32'h0);
        tx_ready = 1'b1;
        repeat (8) tick();
        tx_ready = 1'b0;
        check_state("ovf_drain");

        rx_offer(8'h11);
        rx_offer(8'h22);
        read_reg(STS, got);
        checkOutput("rx_not_empty", {31'h0, got[3]}, 32'h0);
        read_reg(CNT, got);
        checkOutput("rx_count2", {24'h0, got[15:8]}, 32'h2);
        rx_load("rx_load1");
        rx_load("rx_load2");
        rx_load("rx_load_empty");
        read_reg(STS, got);
        checkOutput("rx_empty_bit", {31'h0, got[3]}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            rx_offer(8'(8'h60 + i));
        end
        checkOutput("rx_ready_full", 32'(rx_ready), 32'h0);
        rx_offer(8'hEE);
        check_state("rx_full");
        applyStimulus(RXD, 32'h0, 1'b1, 1'b1);
        check_state("rx_rw_same");
        for (int i = 0; i < 8; i++) begin
            rx_load("rx_drain");
        end
        check_state("rx_drained");

        for (int i = 0; i < 8; i++) begin
            tx_store(8'(8'hB0 + i));
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tx_store(8'(8'h77 + i));
            read_reg(CNT, got);
            checkOutput("wrap_count", {24'h0, got[7:0]}, 32'h8);
        end
        tx_ready = 1'b0;
        check_state("wrap");
        tx_ready = 1'b1;
        repeat (8) tick();
        tx_ready = 1'b0;
        check_state("wrap_drain");

        for (int i = 0; i < 9; i++) begin
            tx_store(8'(8'hC0 + i));
        end
        tx_ready = 1'b1;
        repeat (3) tick();
        tx_ready = 1'b0;
        rx_offer(8'h01);
        rx_offer(8'h02);
        rx_offer(8'h03);
        check_state("pre_reset");
        reset    = 1'b1;
        addr     = TXD;
        wdata    = 32'h55;
        memwrite = 1'b1;
        tx_ready = 1'b1;
        rx_data  = 8'h44;
        rx_valid = 1'b1;
        tick();
        reset    = 1'b0;
        memwrite = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        tx_q.delete();
        rx_q.delete();
        ovf_m = 1'b0;
        read_reg(CNT, got);
        checkOutput("mid_reset_count", got, 32'h0);
        read_reg(STS, got);
        checkOutput("mid_reset_status", got, 32'h0000_000A);
        checkOutput("mid_reset_tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("mid_reset_rx_ready", 32'(rx_ready), 32'h1);
        read_reg(32'h10, got);
        checkOutput("mid_reset_ram", got, 32'hDEAD_BEEF);

        checkOutput("tx_scoreboard_left", 32'(tx_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side responder for the single-cycle core's load/store port. It replaces the bare data memory with an address-decoded target.
- Targets: a word RAM, plus a memory-mapped byte mailbox of two FIFOs.
- The TX FIFO is filled by core stores and drained by an external valid/ready consumer, e.g. the I2C controller.
- The RX FIFO is filled by an external producer and drained by core loads.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of 2, at most 1024.
- FIFO_DEPTH, 8, entries per FIFO; power of 2, at least 2.
- PERIPH_BASE, 32'h0000_1000, base address of the mailbox register block; 16-byte aligned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the core ALU result.
- wdata  in  32  store data (rd2).
- memwrite  in  1  store strobe.
- memread  in  1  load strobe; it is needed for pop-on-read side effects.
- rdata  out  32  load data; combinational from addr.
- tx_data  out  8  head byte of the TX FIFO.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  consumer accepts tx_data on clk edge when tx_valid && tx_ready.
- rx_data  in  8  byte offered by the external producer.
- rx_valid  in  1  producer has a byte.
- rx_ready  out  1  RX FIFO not full; byte is captured on clk edge when rx_valid && rx_ready.

Behaviour:
- Decode:
  - RAM hit when addr < RAM_WORDS*4; word index is addr[log2(RAM_WORDS)+1:2], and addr[1:0] is ignored.
  - Mailbox hit when addr[31:4] == PERIPH_BASE[31:4].
  - Any other address reads 0, and writes to it are ignored.
- RAM:
  - Asynchronous read.
  - Write of the full word on the clk edge when memwrite is high.
  - Contents are not cleared by reset.
- Mailbox offsets:
  - 0x0 TXDATA
    - Write pushes wdata[7:0].
    - If the TX FIFO is full and no pop occurs that cycle, the byte is dropped and tx_ovf (sticky) is set.
    - Reads return 0.
  - 0x4 RXDATA
    - Read returns {24'b0, RX head}; returns 0 if empty.
    - memread && hit && !rx_empty pops on the clk edge.
    - Writes are ignored.
  - 0x8 STATUS
    - Read: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_ovf; other bits 0.
    - Writing 1 to bit4 clears tx_ovf.
  - 0xC COUNT
    - Read: {16'b0, rx_count[7:0], tx_count[7:0]}, counts zero-extended.
    - Writes are ignored.
- memread && memwrite to the same address in one cycle: the write takes effect and no RXDATA pop occurs.
- Reset state:
  - Both FIFOs are empty (pointers and counts 0) and tx_ovf = 0.
  - Outputs: tx_valid = 0, rx_ready = 1, tx_data = 0 (the head slot is driven as 0 while empty), rdata = decode of addr.
- Latency:
  - A push is visible to the far side on the next cycle. A core TXDATA store at edge N gives tx_valid = 1 after edge N.
  - rx_ready and tx_valid are registered-state derived and have no combinational path from addr/memwrite.
- Simultaneous push and pop on a FIFO:
  - When full, the push is accepted and the count is unchanged; the same holds when not empty.
  - When empty, only the push is accepted; the pop is impossible because valid = 0.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits and wrap naturally; the count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-operation:
  - Reset wins over every simultaneous push, pop, or write.
  - Any in-flight TX byte is discarded.
  - RAM is unaffected.

Decomposition:
- Shared package dmem_pkg:
  - Offset constants OFF_TXDATA = 4'h0, OFF_RXDATA = 4'h4, OFF_STATUS = 4'h8, OFF_COUNT = 4'hC.
  - STATUS bit-index constants.
- One sub-module sync_fifo (WIDTH = 8, DEPTH = FIFO_DEPTH), instantiated as the TX and RX FIFOs.
  - Ports: clk, reset, push, push_data, pop, head, full, empty, count.
- Address decode, register mux and RAM stay in the top module.

Test Plan:
- RAM round trip: reset, store 32'hDEADBEEF to addr 0x10, load 0x10 -> rdata = 32'hDEADBEEF. A load from 0x13 returns the same word.
- TX path: with tx_ready = 0, store 0xA5 then 0x3C to PERIPH_BASE+0x0.
  - Expect tx_valid = 1, tx_data = 0xA5, and COUNT = 0x0000_0002.
  - Raise tx_ready for 2 cycles -> 0xA5 then 0x3C are transferred; tx_valid = 0 and STATUS bit1 = 1.
- TX overflow: with tx_ready = 0, perform 9 TXDATA stores of 0..8.
  - Expect STATUS bit0 = 1 and bit4 = 1, and the FIFO holds 0..7.
  - Store 0x10 to STATUS -> bit4 = 0.
  - Drain -> bytes 0..7 in order.
- RX path: producer offers 0x11, 0x22 with rx_valid = 1.
  - Expect STATUS bit3 = 0 and COUNT rx field = 2.
  - Load RXDATA twice with memread = 1 -> 0x11, then 0x22; a third load -> 0 and rx_empty = 1.
  - Fill 8 bytes -> rx_ready = 0.
- Simultaneous and wrap: with the TX FIFO full, a TXDATA store of 0x77 in the same cycle as a tx_ready pop -> count stays 8, 0x77 is at the tail, and tx_ovf stays 0. Repeat for 20 cycles to exercise pointer wrap with data order preserved.
- Reset mid-stream: with 5 bytes in TX, 3 in RX, and tx_ovf = 1, assert reset for 1 cycle.
  - Expect COUNT = 0, STATUS = 32'h0000_000A, tx_valid = 0, rx_ready = 1.
  - The RAM word at 0x10 still reads 32'hDEADBEEF.
